// File: rtl/ula_arbitro.sv
// Round-robin arbiter sharing one 8-bit ULA between two requesters; ops are registered into the ULA,
// results captured one cycle later. Accept-to-response latency 2 cycles; rsp_ready low stalls in RESPONDE.
module ula_arbitro #(
    parameter int DATA_W = 8,
    parameter int OP_W   = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,
    output logic [DATA_W-1:0] ula_entrada1,
    output logic [DATA_W-1:0] ula_entrada2,
    output logic [OP_W-1:0]   ula_op,
    input  logic [DATA_W-1:0] ula_resultado,
    input  logic [DATA_W-1:0] ula_set,
    input  logic              ula_zero,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_resultado,
    output logic [DATA_W-1:0] rsp_set,
    output logic              rsp_zero
);

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        EXECUTA  = 2'd1,
        RESPONDE = 2'd2
    } estado_t;

    estado_t           estado_q, estado_d;
    logic              prioridade_q, prioridade_d;
    logic [DATA_W-1:0] entrada1_q, entrada1_d;
    logic [DATA_W-1:0] entrada2_q, entrada2_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0] rsp_resultado_q, rsp_resultado_d;
    logic [DATA_W-1:0] rsp_set_q, rsp_set_d;
    logic              rsp_zero_q, rsp_zero_d;

    logic grant_vld;
    logic grant_id;
    logic aceite;

    // With both requesters pending the preferred one wins; otherwise whoever is valid.
    assign grant_vld = req0_valid | req1_valid;
    assign grant_id  = (req0_valid & req1_valid) ? prioridade_q : req1_valid;
    assign aceite    = (req0_valid & req0_ready) | (req1_valid & req1_ready);

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= OCIOSO;
        end else begin
            estado_q <= estado_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            OCIOSO:   if (aceite) estado_d = EXECUTA;
            EXECUTA:  estado_d = RESPONDE;
            RESPONDE: if (rsp_ready) estado_d = OCIOSO;
            default:  estado_d = OCIOSO;
        endcase
    end

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (estado_q == OCIOSO && !reset && grant_vld) begin
            req0_ready = (grant_id == 1'b0);
            req1_ready = (grant_id == 1'b1);
        end
    end

    always_comb begin
        prioridade_d    = prioridade_q;
        entrada1_d      = entrada1_q;
        entrada2_d      = entrada2_q;
        op_d            = op_q;
        rsp_id_d        = rsp_id_q;
        rsp_valid_d     = rsp_valid_q;
        rsp_resultado_d = rsp_resultado_q;
        rsp_set_d       = rsp_set_q;
        rsp_zero_d      = rsp_zero_q;
        if (aceite) begin
            entrada1_d   = grant_id ? req1_a  : req0_a;
            entrada2_d   = grant_id ? req1_b  : req0_b;
            op_d         = grant_id ? req1_op : req0_op;
            rsp_id_d     = grant_id;
            prioridade_d = ~grant_id;
        end
        // The ULA has had the registered operands for a full cycle by the end of EXECUTA.
        if (estado_q == EXECUTA) begin
            rsp_resultado_d = ula_resultado;
            rsp_set_d       = ula_set;
            rsp_zero_d      = ula_zero;
            rsp_valid_d     = 1'b1;
        end else if (estado_q == RESPONDE && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prioridade_q    <= 1'b0;
            entrada1_q      <= '0;
            entrada2_q      <= '0;
            op_q            <= '0;
            rsp_id_q        <= 1'b0;
            rsp_valid_q     <= 1'b0;
            rsp_resultado_q <= '0;
            rsp_set_q       <= '0;
            rsp_zero_q      <= 1'b0;
        end else begin
            prioridade_q    <= prioridade_d;
            entrada1_q      <= entrada1_d;
            entrada2_q      <= entrada2_d;
            op_q            <= op_d;
            rsp_id_q        <= rsp_id_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_resultado_q <= rsp_resultado_d;
            rsp_set_q       <= rsp_set_d;
            rsp_zero_q      <= rsp_zero_d;
        end
    end

    assign ula_entrada1  = entrada1_q;
    assign ula_entrada2  = entrada2_q;
    assign ula_op        = op_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_id        = rsp_id_q;
    assign rsp_resultado = rsp_resultado_q;
    assign rsp_set       = rsp_set_q;
    assign rsp_zero      = rsp_zero_q;

endmodule

// File: tb/tb_ula_arbitro.sv
// Bench for ula_arbitro: directed scenarios then random traffic, with a transaction-level model
// predicting grants and a scoreboard monitor checking every response.
module tb_ula_arbitro;

    logic       clock = 1'b0;
    logic       reset;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0] req0_op, req1_op;
    logic [7:0] ula_entrada1, ula_entrada2;
    logic [3:0] ula_op;
    logic [7:0] ula_resultado, ula_set;
    logic       ula_zero;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_zero;
    logic [7:0] rsp_resultado, rsp_set;

    ula_arbitro #(.DATA_W(8), .OP_W(4)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .ula_entrada1(ula_entrada1), .ula_entrada2(ula_entrada2), .ula_op(ula_op),
        .ula_resultado(ula_resultado), .ula_set(ula_set), .ula_zero(ula_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_resultado(rsp_resultado), .rsp_set(rsp_set), .rsp_zero(rsp_zero)
    );

    // Stub ULA: add, set-less-than, zero flag.
    always_comb begin
        ula_resultado = ula_entrada1 + ula_entrada2;
        ula_set       = {7'b0, (ula_entrada1 < ula_entrada2)};
        ula_zero      = (ula_resultado == 8'h00);
    end

    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    typedef struct {
        bit       id;
        bit [7:0] res;
        bit [7:0] set;
        bit       zero;
        int       acc_cyc;
    } exp_t;

    exp_t sb[$];

    // Reference model: transaction-level view of the arbiter.
    bit       m_busy = 0;
    int       m_age  = 0;
    bit       m_prio = 0;
    bit [7:0] m_e1 = 0, m_e2 = 0;
    bit [3:0] m_op = 0;
    bit       rst_pend = 0;
    bit       cont_mode = 0;
    bit       last_acc_vld = 0;
    int       last_acc = 0;

    always @(negedge clock) begin
        bit   g_vld, g_id;
        exp_t e;
        if (rst_pend) begin
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_id", rsp_id, 0);
            chk("rst_rsp_res", rsp_resultado, 0);
            chk("rst_rsp_set", rsp_set, 0);
            chk("rst_rsp_zero", rsp_zero, 0);
            rst_pend = 0;
        end
        chk("ula_entrada1", ula_entrada1, m_e1);
        chk("ula_entrada2", ula_entrada2, m_e2);
        chk("ula_op", ula_op, m_op);
        if (!cont_mode) last_acc_vld = 0;
        if (reset) begin
            chk("rst_req0_ready", req0_ready, 0);
            chk("rst_req1_ready", req1_ready, 0);
            rst_pend = 1;
            m_busy = 0; m_prio = 0; m_e1 = 0; m_e2 = 0; m_op = 0;
            sb.delete();
        end else if (!m_busy) begin
            g_vld = req0_valid || req1_valid;
            g_id  = (req0_valid && req1_valid) ? m_prio : req1_valid;
            chk("req0_ready", req0_ready, g_vld && !g_id);
            chk("req1_ready", req1_ready, g_vld && g_id);
            if (g_vld) begin
                m_e1 = g_id ? req1_a : req0_a;
                m_e2 = g_id ? req1_b : req0_b;
                m_op = g_id ? req1_op : req0_op;
                e.id = g_id;
                e.res = m_e1 + m_e2;
                e.set = (m_e1 < m_e2) ? 8'd1 : 8'd0;
                e.zero = (e.res == 0);
                e.acc_cyc = cyc;
                sb.push_back(e);
                m_prio = !g_id;
                m_busy = 1;
                m_age = 0;
                if (cont_mode && last_acc_vld) chk("acc_spacing", cyc - last_acc, 3);
                last_acc = cyc;
                last_acc_vld = cont_mode;
            end
        end else begin
            chk("busy_req0_ready", req0_ready, 0);
            chk("busy_req1_ready", req1_ready, 0);
            m_age++;
            if (m_age >= 2 && rsp_ready) m_busy = 0;
        end
    end

    // Scoreboard monitor: checks the response channel against queued expectations.
    bit seen = 0;
    always @(negedge clock) begin
        exp_t h;
        if (reset) begin
            seen = 0;
        end else if (rsp_valid) begin
            if (sb.size() == 0) begin
                chk("rsp_spurious", rsp_valid, 0);
            end else begin
                h = sb[0];
                if (!seen) begin
                    chk("rsp_latency", cyc - h.acc_cyc, 2);
                    seen = 1;
                end
                chk("rsp_id", rsp_id, h.id);
                chk("rsp_resultado", rsp_resultado, h.res);
                chk("rsp_set", rsp_set, h.set);
                chk("rsp_zero", rsp_zero, h.zero);
                if (rsp_ready) begin
                    void'(sb.pop_front());
                    seen = 0;
                end
            end
        end
    end

    bit h0, h1;

    task automatic tick();
        @(negedge clock);
        h0 = req0_valid && req0_ready;
        h1 = req1_valid && req1_ready;
        @(posedge clock);
        #1;
    endtask

    task automatic wait_h0();
        int i;
        for (i = 0; i < 40; i++) begin
            tick();
            if (h0) break;
        end
        if (i == 40) chk("timeout_req0", 0, 1);
    endtask

    task automatic wait_h1();
        int i;
        for (i = 0; i < 40; i++) begin
            tick();
            if (h1) break;
        end
        if (i == 40) chk("timeout_req1", 0, 1);
    endtask

    task automatic new0(input bit v);
        req0_valid = v;
        req0_a = 8'($urandom); req0_b = 8'($urandom); req0_op = 4'($urandom);
    endtask

    task automatic new1(input bit v);
        req1_valid = v;
        req1_a = 8'($urandom); req1_b = 8'($urandom); req1_op = 4'($urandom);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; rsp_ready = 1;
        req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0;
        req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0;
        @(posedge clock); #1;
        repeat (3) tick();
        reset = 0;

        // Single request
        req0_valid = 1; req0_a = 8'h01; req0_b = 8'hFF; req0_op = 4'b0010;
        wait_h0();
        req0_valid = 0;
        repeat (5) tick();

        // Priority after reset, then contention
        reset = 1; tick(); reset = 0;
        req1_valid = 1; req1_a = 8'h10; req1_b = 8'h20; req1_op = 4'h3;
        wait_h1();
        new0(1); new1(1);
        cont_mode = 1;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (h0) new0(1);
            if (h1) new1(1);
        end
        cont_mode = 0;
        req0_valid = 0; req1_valid = 0;
        repeat (5) tick();

        // Backpressure
        rsp_ready = 0;
        new1(1);
        wait_h1();
        new1(1);
        repeat (7) tick();
        rsp_ready = 1;
        wait_h1();
        req1_valid = 0;
        repeat (5) tick();

        // Reset during EXECUTA
        new0(1);
        wait_h0();
        req0_valid = 0;
        reset = 1; tick(); reset = 0;
        repeat (4) tick();
        new0(1);
        wait_h0();
        req0_valid = 0;
        repeat (5) tick();

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            if (!req0_valid || h0) new0($urandom_range(0, 2) != 0);
            if (!req1_valid || h1) new1($urandom_range(0, 2) != 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 59) == 0);
            tick();
        end
        reset = 0; rsp_ready = 1; req0_valid = 0; req1_valid = 0;
        repeat (10) tick();
        chk("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
